wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 15 +
 rtl/wb_arbiter.sv | 175 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Pipelined Wishbone bundle used by the arbiter's masters and its shared downstream bus.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        stall;

  modport master (output cyc, stb, we, sel, adr, dat_m, input dat_s, ack, stall);
  modport slave  (input cyc, stb, we, sel, adr, dat_m, output dat_s, ack, stall);
endinterface

// File: rtl/wb_arbiter.sv
// Four-master pipelined Wishbone arbiter with bus lock and an outstanding-strobe limit.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority m0 > m3 otherwise.
module wb_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  if_wb.slave        m0,
  if_wb.slave        m1,
  if_wb.slave        m2,
  if_wb.slave        m3,
  if_wb.master       sbus,
  output logic [3:0] gnt_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  state_t            state_r, state_s;
  logic [3:0]        gnt_r, gnt_s;
  logic [1:0]        last_r, last_s;
  logic [3:0]        cnt_r, cnt_s;

  logic [3:0]        m_cyc_s, m_stb_s, m_we_s;
  logic [3:0][3:0]   m_sel_s;
  logic [3:0][31:0]  m_adr_s, m_wdat_s, m_rdat_s;
  logic [3:0]        m_ack_s, m_stall_s;

  logic [1:0]        base_s, enc_s, win_s, gidx_s;
  logic [3:0]        rot_s;
  logic              win_vld_s, full_s, inc_s, dec_s;

  logic              bus_cyc_s, bus_stb_s, bus_we_s;
  logic [3:0]        bus_sel_s;
  logic [31:0]       bus_adr_s, bus_wdat_s;

  assign m_cyc_s  = {m3.cyc, m2.cyc, m1.cyc, m0.cyc};
  assign m_stb_s  = {m3.stb, m2.stb, m1.stb, m0.stb};
  assign m_we_s   = {m3.we, m2.we, m1.we, m0.we};
  assign m_sel_s  = {m3.sel, m2.sel, m1.sel, m0.sel};
  assign m_adr_s  = {m3.adr, m2.adr, m1.adr, m0.adr};
  assign m_wdat_s = {m3.dat_m, m2.dat_m, m1.dat_m, m0.dat_m};

  // Pick the winner among current requesters
  always_comb begin
    win_vld_s = |m_cyc_s;
`ifdef ARB_ROUND_ROBIN_EN
    base_s = last_r + 2'd1;
    rot_s  = 4'(({m_cyc_s, m_cyc_s}) >> base_s);
`else
    base_s = 2'd0;
    rot_s  = m_cyc_s;
`endif
    casez (rot_s)
      4'b???1: enc_s = 2'd0;
      4'b??10: enc_s = 2'd1;
      4'b?100: enc_s = 2'd2;
      4'b1000: enc_s = 2'd3;
      default: enc_s = 2'd0;
    endcase
    win_s = base_s + enc_s;
  end

  // Index of the master currently owning the bus
  always_comb begin
    case (gnt_r)
      4'b0001: gidx_s = 2'd0;
      4'b0010: gidx_s = 2'd1;
      4'b0100: gidx_s = 2'd2;
      4'b1000: gidx_s = 2'd3;
      default: gidx_s = 2'd0;
    endcase
  end

  // Next state, outstanding count and bus routing
  always_comb begin
    state_s    = state_r;
    gnt_s      = gnt_r;
    last_s     = last_r;
    cnt_s      = cnt_r;
    bus_cyc_s  = 1'b0;
    bus_stb_s  = 1'b0;
    bus_we_s   = 1'b0;
    bus_sel_s  = 4'b0000;
    bus_adr_s  = 32'd0;
    bus_wdat_s = 32'd0;
    m_rdat_s   = '0;
    m_ack_s    = 4'b0000;
    m_stall_s  = 4'b1111;
    full_s     = 1'b0;
    inc_s      = 1'b0;
    dec_s      = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = 4'd0;
        if (win_vld_s) begin
          state_s = GRANT;
          gnt_s   = 4'b0001 << win_s;
          last_s  = win_s;
        end else begin
          gnt_s = 4'b0000;
        end
      end
      GRANT: begin
        if (m_cyc_s[gidx_s]) begin
          // A full window only opens when an ack retires a slot this same cycle
          full_s     = (cnt_r >= MAX_CNT) && !sbus.ack;
          bus_cyc_s  = 1'b1;
          bus_stb_s  = m_stb_s[gidx_s] && !full_s;
          bus_we_s   = m_we_s[gidx_s];
          bus_sel_s  = m_sel_s[gidx_s];
          bus_adr_s  = m_adr_s[gidx_s];
          bus_wdat_s = m_wdat_s[gidx_s];
          m_rdat_s[gidx_s]  = sbus.dat_s;
          m_ack_s[gidx_s]   = sbus.ack;
          m_stall_s[gidx_s] = sbus.stall || full_s;
          inc_s = bus_stb_s && !sbus.stall;
          dec_s = sbus.ack && (cnt_r != 4'd0);
          case ({inc_s, dec_s})
            2'b10:   cnt_s = cnt_r + 4'd1;
            2'b01:   cnt_s = cnt_r - 4'd1;
            default: cnt_s = cnt_r;
          endcase
        end else begin
          state_s = IDLE;
          gnt_s   = 4'b0000;
          cnt_s   = 4'd0;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 4'b0000;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, grant, last-grant pointer and outstanding count registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      gnt_r   <= 4'b0000;
      last_r  <= 2'd3;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      last_r  <= last_s;
      cnt_r   <= cnt_s;
    end
  end

  assign gnt_o      = gnt_r;
  assign sbus.cyc   = bus_cyc_s;
  assign sbus.stb   = bus_stb_s;
  assign sbus.we    = bus_we_s;
  assign sbus.sel   = bus_sel_s;
  assign sbus.adr   = bus_adr_s;
  assign sbus.dat_m = bus_wdat_s;

  assign m0.dat_s = m_rdat_s[0];
  assign m1.dat_s = m_rdat_s[1];
  assign m2.dat_s = m_rdat_s[2];
  assign m3.dat_s = m_rdat_s[3];
  assign m0.ack   = m_ack_s[0];
  assign m1.ack   = m_ack_s[1];
  assign m2.ack   = m_ack_s[2];
  assign m3.ack   = m_ack_s[3];
  assign m0.stall = m_stall_s[0];
  assign m1.stall = m_stall_s[1];
  assign m2.stall = m_stall_s[2];
  assign m3.stall = m_stall_s[3];

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected bus accepts and master acks are queued by the
// stimulus and retired by a negedge monitor; grant/stall levels are checked directly.
module tb_wb_arbiter;
  logic clk_i = 1'b0;
  logic rst_i;
  logic [3:0] gnt_o;

  always #5 clk_i = ~clk_i;

  if_wb m0_if();
  if_wb m1_if();
  if_wb m2_if();
  if_wb m3_if();
  if_wb sbus_if();

  wb_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0(m0_if), .m1(m1_if), .m2(m2_if), .m3(m3_if),
    .sbus(sbus_if), .gnt_o(gnt_o)
  );

  typedef struct { logic [3:0] gnt; logic [31:0] adr; } acc_t;
  typedef struct { int idx; logic [31:0] dat; } ack_t;
  acc_t acc_q[$];
  ack_t ack_q[$];
  acc_t acc_e;
  ack_t ack_e;

  int checks = 0;
  int failures = 0;

  logic [3:0]  ack_v;
  logic [31:0] rdat [4];
  assign ack_v   = {m3_if.ack, m2_if.ack, m1_if.ack, m0_if.ack};
  assign rdat[0] = m0_if.dat_s;
  assign rdat[1] = m1_if.dat_s;
  assign rdat[2] = m2_if.dat_s;
  assign rdat[3] = m3_if.dat_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drv(input int i, input logic cyc, input logic stb, input logic [31:0] adr);
    case (i)
      0: begin m0_if.cyc = cyc; m0_if.stb = stb; m0_if.adr = adr; end
      1: begin m1_if.cyc = cyc; m1_if.stb = stb; m1_if.adr = adr; end
      2: begin m2_if.cyc = cyc; m2_if.stb = stb; m2_if.adr = adr; end
      default: begin m3_if.cyc = cyc; m3_if.stb = stb; m3_if.adr = adr; end
    endcase
  endtask

  task automatic exp_acc(input logic [3:0] g, input logic [31:0] a);
    acc_t e;
    e.gnt = g;
    e.adr = a;
    acc_q.push_back(e);
  endtask

  task automatic exp_ack(input int i, input logic [31:0] d);
    ack_t e;
    e.idx = i;
    e.dat = d;
    ack_q.push_back(e);
  endtask

  task automatic slv(input logic ack, input logic [31:0] dat);
    sbus_if.ack   = ack;
    sbus_if.dat_s = dat;
  endtask

  // Monitor: retire queued expectations whenever the DUT presents an accept or an ack
  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && sbus_if.cyc && sbus_if.stb && !sbus_if.stall) begin
      if (acc_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_accept: got adr %h gnt %b expected none", sbus_if.adr, gnt_o);
      end else begin
        acc_e = acc_q.pop_front();
        chk("accept_adr", sbus_if.adr, acc_e.adr);
        chk("accept_gnt", {28'd0, gnt_o}, {28'd0, acc_e.gnt});
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (ack_v[i] === 1'b1) begin
        if (ack_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: got ack on m%0d expected none", i);
        end else begin
          ack_e = ack_q.pop_front();
          chk("ack_master", 32'(i), 32'(ack_e.idx));
          chk("ack_data", rdat[i], ack_e.dat);
        end
      end
    end
  end

  initial begin
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) drv(i, 1'b0, 1'b0, 32'd0);
    m0_if.we = 1'b0; m1_if.we = 1'b0; m2_if.we = 1'b0; m3_if.we = 1'b0;
    m0_if.sel = 4'hf; m1_if.sel = 4'hf; m2_if.sel = 4'hf; m3_if.sel = 4'hf;
    m0_if.dat_m = 32'd0; m1_if.dat_m = 32'd0; m2_if.dat_m = 32'd0; m3_if.dat_m = 32'd0;
    sbus_if.stall = 1'b0;
    slv(1'b0, 32'd0);

    // Reset holds everything idle even with a request pending
    drv(0, 1'b1, 1'b0, 32'd0);
    repeat (2) tick();
    @(negedge clk_i);
    chk("rst_gnt", {28'd0, gnt_o}, 32'd0);
    chk("rst_sbus_cyc", 32'(sbus_if.cyc), 32'd0);
    chk("rst_m0_stall", 32'(m0_if.stall), 32'd1);
    chk("rst_m0_ack", 32'(m0_if.ack), 32'd0);
    tick();
    rst_i = 1'b1;
    drv(0, 1'b0, 1'b0, 32'd0);
    tick();

    // Single m2 transfer: one-cycle arbitration, ack one cycle after accept
    drv(2, 1'b1, 1'b1, 32'h1000_0000);
    exp_acc(4'b0100, 32'h1000_0000);
    @(negedge clk_i);
    chk("arb_latency_cyc", 32'(sbus_if.cyc), 32'd0);
    tick();
    @(negedge clk_i);
    chk("m2_gnt", {28'd0, gnt_o}, 32'h4);
    tick();
    drv(2, 1'b1, 1'b0, 32'h1000_0000);
    slv(1'b1, 32'hCAFE_0002);
    exp_ack(2, 32'hCAFE_0002);
    tick();
    slv(1'b0, 32'd0);
    drv(2, 1'b0, 1'b0, 32'd0);
    @(negedge clk_i);
    chk("release_cyc", 32'(sbus_if.cyc), 32'd0);
    tick();
    @(negedge clk_i);
    chk("release_gnt", {28'd0, gnt_o}, 32'd0);

    // m0 and m3 together, three rounds from pointer 3
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    for (int r = 0; r < 3; r++) begin
      drv(0, 1'b1, 1'b0, 32'd0);
      drv(3, 1'b1, 1'b0, 32'd0);
      tick();
      @(negedge clk_i);
      chk("pair_first_m0", {28'd0, gnt_o}, 32'h1);
      tick();
      drv(0, 1'b0, 1'b0, 32'd0);
      @(negedge clk_i);
      chk("pair_drop_cyc", 32'(sbus_if.cyc), 32'd0);
      tick();
      @(negedge clk_i);
      chk("pair_idle_gap", {28'd0, gnt_o}, 32'd0);
      tick();
      @(negedge clk_i);
      chk("pair_then_m3", {28'd0, gnt_o}, 32'h8);
      tick();
      drv(3, 1'b0, 1'b0, 32'd0);
      tick();
      tick();
    end

    // m0 re-requests in the idle gap while m1 waits
    drv(0, 1'b1, 1'b0, 32'd0);
    drv(1, 1'b1, 1'b0, 32'd0);
    tick();
    @(negedge clk_i);
    chk("m01_first", {28'd0, gnt_o}, 32'h1);
    tick();
    drv(0, 1'b0, 1'b0, 32'd0);
    tick();
    drv(0, 1'b1, 1'b0, 32'd0);
    @(negedge clk_i);
    chk("m01_idle", {28'd0, gnt_o}, 32'd0);
    tick();
    @(negedge clk_i);
`ifdef ARB_ROUND_ROBIN_EN
    chk("m01_second", {28'd0, gnt_o}, 32'h2);
`else
    chk("m01_second", {28'd0, gnt_o}, 32'h1);
`endif
    drv(0, 1'b0, 1'b0, 32'd0);
    drv(1, 1'b0, 1'b0, 32'd0);
    tick();
    tick();

    // Outstanding limit: six strobes from m1, slave silent
    drv(1, 1'b1, 1'b1, 32'h2000_0000);
    for (int i = 0; i < 4; i++) exp_acc(4'b0010, 32'h2000_0000 + 32'(i));
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("lim_open_stall", 32'(m1_if.stall), 32'd0);
      tick();
      drv(1, 1'b1, 1'b1, 32'h2000_0000 + 32'(i + 1));
    end
    repeat (3) begin
      @(negedge clk_i);
      chk("lim_full_stall", 32'(m1_if.stall), 32'd1);
      chk("lim_full_stb", 32'(sbus_if.stb), 32'd0);
      tick();
    end
    slv(1'b1, 32'hA5A5_0001);
    exp_acc(4'b0010, 32'h2000_0004);
    exp_ack(1, 32'hA5A5_0001);
    @(negedge clk_i);
    chk("lim_ack_opens", 32'(m1_if.stall), 32'd0);
    tick();
    slv(1'b0, 32'd0);
    drv(1, 1'b1, 1'b1, 32'h2000_0005);
    @(negedge clk_i);
    chk("lim_refull_stall", 32'(m1_if.stall), 32'd1);
    tick();
    slv(1'b1, 32'hA5A5_0002);
    exp_acc(4'b0010, 32'h2000_0005);
    exp_ack(1, 32'hA5A5_0002);
    tick();
    slv(1'b0, 32'd0);
    drv(1, 1'b1, 1'b0, 32'h2000_0005);
    @(negedge clk_i);
    chk("lim_full_nostb", 32'(m1_if.stall), 32'd1);
    tick();
    drv(1, 1'b0, 1'b0, 32'd0);
    slv(1'b1, 32'hA5A5_0003);
    @(negedge clk_i);
    chk("late_ack_blocked", 32'(m1_if.ack), 32'd0);
    chk("late_ack_cyc", 32'(sbus_if.cyc), 32'd0);
    tick();
    slv(1'b0, 32'd0);
    tick();

    // Bus lock: m3 waits 20 cycles behind m1
    drv(1, 1'b1, 1'b0, 32'd0);
    tick();
    drv(3, 1'b1, 1'b1, 32'h3000_0000);
    exp_acc(4'b1000, 32'h3000_0000);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        slv(1'b1, 32'h5555_AAAA);
        exp_ack(1, 32'h5555_AAAA);
      end else begin
        slv(1'b0, 32'h5555_AAAA);
      end
      @(negedge clk_i);
      chk("lock_m3_stall", 32'(m3_if.stall), 32'd1);
      chk("lock_m3_ack", 32'(m3_if.ack), 32'd0);
      chk("lock_m3_dat", m3_if.dat_s, 32'd0);
      chk("lock_gnt", {28'd0, gnt_o}, 32'h2);
      tick();
    end
    slv(1'b0, 32'd0);
    drv(1, 1'b0, 1'b0, 32'd0);
    tick();
    @(negedge clk_i);
    chk("lock_idle", {28'd0, gnt_o}, 32'd0);
    tick();
    @(negedge clk_i);
    chk("lock_m3_gnt", {28'd0, gnt_o}, 32'h8);
    tick();
    drv(3, 1'b0, 1'b0, 32'd0);
    tick();
    tick();

    // Reset while m0 has two strobes outstanding
    drv(0, 1'b1, 1'b1, 32'h4000_0000);
    exp_acc(4'b0001, 32'h4000_0000);
    exp_acc(4'b0001, 32'h4000_0004);
    tick();
    tick();
    drv(0, 1'b1, 1'b1, 32'h4000_0004);
    tick();
    drv(0, 1'b1, 1'b0, 32'h4000_0004);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    drv(0, 1'b0, 1'b0, 32'd0);
    slv(1'b1, 32'hDEAD_0000);
    @(negedge clk_i);
    chk("midrst_gnt", {28'd0, gnt_o}, 32'd0);
    chk("midrst_cyc", 32'(sbus_if.cyc), 32'd0);
    chk("midrst_m0_ack", 32'(m0_if.ack), 32'd0);
    tick();
    slv(1'b0, 32'd0);
    tick();

    // Accept and ack together at MAX-1 keep the window steady
    drv(1, 1'b1, 1'b1, 32'h5000_0000);
    for (int i = 0; i < 3; i++) exp_acc(4'b0010, 32'h5000_0000 + 32'(i));
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      drv(1, 1'b1, 1'b1, 32'h5000_0001 + 32'(i));
    end
    for (int i = 0; i < 10; i++) begin
      slv(1'b1, 32'h6000_0000 + 32'(i));
      exp_acc(4'b0010, 32'h5000_0003 + 32'(i));
      exp_ack(1, 32'h6000_0000 + 32'(i));
      @(negedge clk_i);
      chk("steady_no_stall", 32'(m1_if.stall), 32'd0);
      tick();
      drv(1, 1'b1, 1'b1, 32'h5000_0004 + 32'(i));
    end
    slv(1'b0, 32'd0);
    exp_acc(4'b0010, 32'h5000_000D);
    @(negedge clk_i);
    chk("steady_last_slot", 32'(m1_if.stall), 32'd0);
    tick();
    drv(1, 1'b1, 1'b1, 32'h5000_000E);
    @(negedge clk_i);
    chk("steady_now_full", 32'(m1_if.stall), 32'd1);
    tick();
    drv(1, 1'b0, 1'b0, 32'd0);
    tick();
    tick();

    chk("acc_queue_empty", 32'(acc_q.size()), 32'd0);
    chk("ack_queue_empty", 32'(ack_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
